// File: rtl/multdiv_pkg.sv
// Shared state encoding, widths and defaults for the mult/div issue controller.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package multdiv_pkg;

    localparam int TIMEOUT_DEF = 48;
    localparam int TAG_W_DEF   = 5;
    localparam int OPA_W       = 32;
    localparam int OPB_W       = 16;
    localparam int RES_W       = 32;

    // Controller states; IDLE must stay at zero so a cleared register is idle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BUSY  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } mdc_state_e;

    // States in which the pipeline is still owed a result for the latched tag.
    function automatic logic owes_result(input mdc_state_e st);
        return (st == START) || (st == BUSY) || (st == DONE);
    endfunction

    // Bits needed to count 0 .. limit-1, never less than one.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/mdc_timeout_cnt.sv
// Clearable cycle counter that saturates at LIMIT-1 and flags that value.
// Latency: tc_o is a decode of the registered count, valid the cycle after the edge.
// Backpressure: none; inc_i may be held high indefinitely, the count just stops.
module mdc_timeout_cnt
    import multdiv_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int               CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; the count holds once it reaches the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller sitting between the pipeline and an iterative mult/div unit.
// Latency: start pulse one cycle after md_inputRDY in START; result visible the cycle after md_resultRDY.
// Backpressure: iss_ready only in IDLE; a result is held in DONE until wb_ack or flush.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    // issue side
    input  logic             iss_valid,
    input  logic             iss_isDiv,
    input  logic [OPA_W-1:0] iss_opA,
    input  logic [OPB_W-1:0] iss_opB,
    input  logic [TAG_W-1:0] iss_tag,
    output logic             iss_ready,
    input  logic             flush,
    // decode-stage hazard check
    input  logic [TAG_W-1:0] rd_tagA,
    input  logic [TAG_W-1:0] rd_tagB,
    output logic             hazard_stall,
    // mult/div unit
    output logic [OPA_W-1:0] md_operandA,
    output logic [OPB_W-1:0] md_operandB,
    output logic             md_MULT,
    output logic             md_DIV,
    input  logic [RES_W-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_inputRDY,
    input  logic             md_resultRDY,
    // writeback side
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic [RES_W-1:0] wb_data,
    output logic             wb_exception,
    output logic             wb_timeout,
    input  logic             wb_ack
);

    mdc_state_e       state_q;
    logic [OPA_W-1:0] opa_q;
    logic [OPB_W-1:0] opb_q;
    logic             is_div_q;
    logic [TAG_W-1:0] tag_q;
    logic [RES_W-1:0] wb_data_q;
    logic             wb_exc_q;
    logic             wb_to_q;
    logic             md_mult_q;
    logic             md_div_q;

    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic             start_go;
    logic             tag_hit;

    // The unit accepts operands this cycle unless the operation is being aborted.
    assign start_go = (state_q == START) && md_inputRDY && !flush;

    // The counter restarts on the start pulse and keeps running through DRAIN so a
    // flushed operation still gives up after TIMEOUT cycles from its start.
    assign cnt_clr = start_go;
    assign cnt_inc = ((state_q == BUSY) || (state_q == DRAIN)) && !md_resultRDY;

    mdc_timeout_cnt #(
        .LIMIT      (TIMEOUT)
    ) u_timeout_cnt (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .tc_o       (cnt_tc)
    );

    // Controller FSM; every registered output is updated here alongside the state.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            tag_q     <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
            wb_to_q   <= 1'b0;
            md_mult_q <= 1'b0;
            md_div_q  <= 1'b0;
        end else begin
            // Start pulses are single-cycle by construction.
            md_mult_q <= 1'b0;
            md_div_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iss_valid) begin
                        opa_q     <= iss_opA;
                        opb_q     <= iss_opB;
                        is_div_q  <= iss_isDiv;
                        tag_q     <= iss_tag;
                        wb_data_q <= '0;
                        wb_to_q   <= 1'b0;
                        // Divide-by-zero never reaches the unit; it is reported directly.
                        if (iss_isDiv && (iss_opB == '0)) begin
                            wb_exc_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            wb_exc_q <= 1'b0;
                            state_q  <= START;
                        end
                    end
                end
                START: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (md_inputRDY) begin
                        md_mult_q <= !is_div_q;
                        md_div_q  <= is_div_q;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    // A returning result beats a same-cycle timeout; a flush on the
                    // finishing cycle has nothing left to drain.
                    if (md_resultRDY) begin
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            wb_data_q <= md_result;
                            wb_exc_q  <= md_exception;
                            wb_to_q   <= 1'b0;
                            state_q   <= DONE;
                        end
                    end else if (cnt_tc) begin
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            wb_data_q <= '0;
                            wb_exc_q  <= 1'b1;
                            wb_to_q   <= 1'b1;
                            state_q   <= DONE;
                        end
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DONE: begin
                    if (flush || wb_ack) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    // The unit is still working; wait it out and discard the answer.
                    if (md_resultRDY || cnt_tc) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decode-stage stall: a nonzero pending tag matched by either source operand.
    always_comb begin
        tag_hit      = (rd_tagA == tag_q) || (rd_tagB == tag_q);
        hazard_stall = owes_result(state_q) && (tag_q != '0) && tag_hit;
    end

    assign iss_ready    = (state_q == IDLE);
    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign md_MULT      = md_mult_q;
    assign md_DIV       = md_div_q;
    assign wb_valid     = (state_q == DONE);
    assign wb_tag       = tag_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exc_q;
    assign wb_timeout   = wb_to_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with a behavioural mult/div unit and a result scoreboard.
// Latency: the unit model raises md_resultRDY model_delay cycles after a start pulse.
// Backpressure: md_inputRDY and wb_ack are driven directly by the stimulus.
module tb_multdiv_ctrl;

    localparam int TAG_W = 5;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             exc;
        logic             to;
    } exp_t;

    logic             clock = 1'b0;
    logic             ctrl_reset;
    logic             iss_valid;
    logic             iss_isDiv;
    logic [31:0]      iss_opA;
    logic [15:0]      iss_opB;
    logic [TAG_W-1:0] iss_tag;
    logic             iss_ready;
    logic             flush;
    logic [TAG_W-1:0] rd_tagA;
    logic [TAG_W-1:0] rd_tagB;
    logic             hazard_stall;
    logic [31:0]      md_operandA;
    logic [15:0]      md_operandB;
    logic             md_MULT;
    logic             md_DIV;
    logic [31:0]      md_result    = '0;
    logic             md_exception = 1'b0;
    logic             md_inputRDY;
    logic             md_resultRDY = 1'b0;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_exception;
    logic             wb_timeout;
    logic             wb_ack;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    int          model_delay = 0;
    int          model_cnt   = 0;
    int          mult_pulses = 0;
    int          div_pulses  = 0;
    logic [31:0] model_res   = '0;

    multdiv_ctrl #(
        .TIMEOUT      (48),
        .TAG_W        (TAG_W)
    ) dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .iss_valid    (iss_valid),
        .iss_isDiv    (iss_isDiv),
        .iss_opA      (iss_opA),
        .iss_opB      (iss_opB),
        .iss_tag      (iss_tag),
        .iss_ready    (iss_ready),
        .flush        (flush),
        .rd_tagA      (rd_tagA),
        .rd_tagB      (rd_tagB),
        .hazard_stall (hazard_stall),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_MULT      (md_MULT),
        .md_DIV       (md_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_inputRDY  (md_inputRDY),
        .md_resultRDY (md_resultRDY),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .wb_exception (wb_exception),
        .wb_timeout   (wb_timeout),
        .wb_ack       (wb_ack)
    );

    always #5 clock = ~clock;

    // Behavioural mult/div unit: computes on a start pulse, answers model_delay cycles later
    // (model_delay 0 means it never answers).
    always begin
        @(posedge clock);
        if (md_MULT === 1'b1) mult_pulses++;
        if (md_DIV === 1'b1) div_pulses++;
        if (md_MULT === 1'b1 || md_DIV === 1'b1) begin
            model_cnt = model_delay;
            if (md_DIV === 1'b1)
                model_res = (md_operandB == 16'd0) ? 32'd0
                          : 32'($signed(md_operandA) / $signed(md_operandB));
            else
                model_res = 32'($signed(md_operandA) * $signed(md_operandB));
        end else if (model_cnt > 0) begin
            model_cnt--;
        end
        #1;
        md_result    = model_res;
        md_resultRDY = (model_cnt == 1);
    end

    // Hard stop in case a wait is ever left unbounded.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic is_div, input logic [31:0] a, input logic [15:0] b,
                         input logic [TAG_W-1:0] tag);
        iss_valid = 1'b1;
        iss_isDiv = is_div;
        iss_opA   = a;
        iss_opB   = b;
        iss_tag   = tag;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [TAG_W-1:0] tag, input logic [31:0] data,
                            input logic exc, input logic to);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.exc  = exc;
        e.to   = to;
        sb.push_back(e);
    endtask

    // Wait (bounded) for wb_valid; returns the number of cycles waited.
    task automatic wait_wb(input int max, output int n);
        n = 0;
        while (wb_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("wb_valid_arrives", 32'(wb_valid), 32'd1);
    endtask

    // Compare the presented writeback against the oldest expected result.
    task automatic sb_check(input string name);
        exp_t e;
        chk({name, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({name, "_tag"}, 32'(wb_tag), 32'(e.tag));
            chk({name, "_data"}, wb_data, e.data);
            chk({name, "_exc"}, 32'(wb_exception), 32'(e.exc));
            chk({name, "_timeout"}, 32'(wb_timeout), 32'(e.to));
        end
    endtask

    task automatic ack();
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
    endtask

    initial begin
        int n;
        int p0;
        int a;
        int b;
        logic seen;

        ctrl_reset  = 1'b1;
        iss_valid   = 1'b0;
        iss_isDiv   = 1'b0;
        iss_opA     = '0;
        iss_opB     = '0;
        iss_tag     = '0;
        flush       = 1'b0;
        rd_tagA     = '0;
        rd_tagB     = '0;
        md_inputRDY = 1'b1;
        wb_ack      = 1'b0;
        repeat (3) tick();
        ctrl_reset = 1'b0;
        tick();

        // Reset state
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_exc", 32'(wb_exception), 32'd0);
        chk("rst_wb_timeout", 32'(wb_timeout), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_md_mult", 32'(md_MULT), 32'd0);
        chk("rst_md_div", 32'(md_DIV), 32'd0);
        chk("rst_hazard", 32'(hazard_stall), 32'd0);
        chk("rst_opA", md_operandA, 32'd0);

        // Multiply 1234 * -56, tag 7, answer 5 cycles after the start pulse
        model_delay = 5;
        p0 = mult_pulses;
        a = 1234;
        b = -56;
        push_exp(5'd7, 32'(a * b), 1'b0, 1'b0);
        issue(1'b0, 32'd1234, 16'(-56), 5'd7);
        chk("mul_start_not_ready", 32'(iss_ready), 32'd0);
        tick();
        chk("mul_pulse", 32'(md_MULT), 32'd1);
        chk("mul_no_div", 32'(md_DIV), 32'd0);
        chk("mul_opA", md_operandA, 32'd1234);
        chk("mul_opB", 32'(md_operandB), 32'(16'hFFC8));
        tick();
        chk("mul_pulse_one_cycle", 32'(md_MULT), 32'd0);
        wait_wb(20, n);
        chk("mul_latency", 32'(n), 32'd5);
        chk("mul_pulse_count", 32'(mult_pulses - p0), 32'd1);
        sb_check("mul");
        tick();
        chk("mul_wb_held", 32'(wb_valid), 32'd1);
        chk("mul_data_stable", wb_data, 32'(a * b));
        ack();
        chk("mul_idle_after_ack", 32'(iss_ready), 32'd1);
        chk("mul_wb_dropped", 32'(wb_valid), 32'd0);

        // Divide 100000 / 0, tag 3: reported without touching the unit
        p0 = div_pulses;
        push_exp(5'd3, 32'd0, 1'b1, 1'b0);
        issue(1'b1, 32'd100000, 16'd0, 5'd3);
        chk("dz_wb_valid_1", 32'(wb_valid), 32'd1);
        sb_check("dz");
        tick();
        chk("dz_wb_valid_2", 32'(wb_valid), 32'd1);
        chk("dz_no_div_pulse", 32'(div_pulses - p0), 32'd0);
        ack();
        chk("dz_idle", 32'(iss_ready), 32'd1);

        // Divide -7 / 2 that never answers: timeout after 48 BUSY cycles;
        // md_inputRDY low for two cycles first keeps the controller in START
        model_delay = 0;
        md_inputRDY = 1'b0;
        p0 = div_pulses;
        push_exp(5'd12, 32'd0, 1'b1, 1'b1);
        issue(1'b1, 32'(-7), 16'd2, 5'd12);
        tick();
        chk("to_start_hold_div", 32'(md_DIV), 32'd0);
        chk("to_start_hold_ready", 32'(iss_ready), 32'd0);
        md_inputRDY = 1'b1;
        tick();
        chk("to_div_pulse", 32'(md_DIV), 32'd1);
        wait_wb(100, n);
        chk("to_busy_cycles", 32'(n), 32'd48);
        chk("to_div_pulse_count", 32'(div_pulses - p0), 32'd1);
        sb_check("to");
        ack();

        // Flush in BUSY cycle 2, unit answers at BUSY cycle 5: drained, nothing written back
        model_delay = 5;
        issue(1'b0, 32'd3, 16'd4, 5'd5);
        tick();
        tick();
        tick();
        seen = wb_valid;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen |= wb_valid;
        tick();
        seen |= wb_valid;
        tick();
        seen |= wb_valid;
        chk("fl_drain_busy", 32'(iss_ready), 32'd0);
        tick();
        seen |= wb_valid;
        chk("fl_ready_after_rdy", 32'(iss_ready), 32'd1);
        chk("fl_no_wb", 32'(seen), 32'd0);

        // Hazard on pending tag 9
        model_delay = 10;
        push_exp(5'd9, 32'd6, 1'b0, 1'b0);
        issue(1'b0, 32'd2, 16'd3, 5'd9);
        rd_tagB = 5'd9;
        #1;
        chk("hz_start_tagB", 32'(hazard_stall), 32'd1);
        tick();
        chk("hz_busy_tagB", 32'(hazard_stall), 32'd1);
        rd_tagB = 5'd8;
        rd_tagA = 5'd9;
        #1;
        chk("hz_busy_tagA", 32'(hazard_stall), 32'd1);
        rd_tagA = 5'd2;
        #1;
        chk("hz_busy_nomatch", 32'(hazard_stall), 32'd0);
        wait_wb(30, n);
        sb_check("hz");
        rd_tagA = 5'd9;
        #1;
        chk("hz_done_tagA", 32'(hazard_stall), 32'd1);
        ack();
        chk("hz_idle_none", 32'(hazard_stall), 32'd0);
        rd_tagA = 5'd0;
        rd_tagB = 5'd0;

        // Pending tag 0 never stalls but still writes back
        a = -5;
        push_exp(5'd0, 32'(a * 7), 1'b0, 1'b0);
        issue(1'b0, 32'(-5), 16'd7, 5'd0);
        tick();
        #1;
        chk("hz_tag0_busy", 32'(hazard_stall), 32'd0);
        wait_wb(30, n);
        sb_check("tag0");
        ack();

        // Reset in BUSY: everything cleared, the late answer is ignored
        model_delay = 5;
        issue(1'b0, 32'd11, 16'd13, 5'd4);
        tick();
        tick();
        rd_tagA = 5'd4;
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        #1;
        chk("mr_iss_ready", 32'(iss_ready), 32'd1);
        chk("mr_wb_valid", 32'(wb_valid), 32'd0);
        chk("mr_opA", md_operandA, 32'd0);
        chk("mr_opB", 32'(md_operandB), 32'd0);
        chk("mr_wb_tag", 32'(wb_tag), 32'd0);
        chk("mr_md_mult", 32'(md_MULT), 32'd0);
        chk("mr_hazard", 32'(hazard_stall), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen |= wb_valid;
        end
        chk("mr_late_rdy_no_wb", 32'(seen), 32'd0);
        chk("mr_still_ready", 32'(iss_ready), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameters: TIMEOUT, default 48, max cycles from start pulse to md_resultRDY; TAG_W, default 5, destination-register tag width.
REQ-002 SHALL have ports:
  - clock  in  1  sole clock, rising edge.
  - ctrl_reset  in  1  synchronous, active-high reset.
  - iss_valid  in  1  pipeline requests a mult/div.
  - iss_isDiv  in  1  1=divide, 0=multiply.
  - iss_opA  in  32  signed operand A.
  - iss_opB  in  16  signed operand B.
  - iss_tag  in  TAG_W  destination register.
  - iss_ready  out  1  request accepted this cycle.
  - flush  in  1  abort in-flight operation, no writeback.
  - rd_tagA, rd_tagB  in  TAG_W each  source tags of the decoding instruction.
  - hazard_stall  out  1  decoding instruction needs the pending result.
  - md_operandA  out  32  to multdiv.
  - md_operandB  out  16  to multdiv.
  - md_MULT, md_DIV  out  1 each  start pulses to multdiv.
  - md_result  in  32  from multdiv.
  - md_exception, md_inputRDY, md_resultRDY  in  1 each  from multdiv.
  - wb_valid  out  1  result pending writeback.
  - wb_tag  out  TAG_W  writeback register.
  - wb_data  out  32  writeback value.
  - wb_exception  out  1  overflow, divide-by-zero or timeout.
  - wb_timeout  out  1  exception caused by timeout.
  - wb_ack  in  1  writeback consumed.

Function
REQ-003 SHALL implement FSM states IDLE, START, BUSY, DONE, DRAIN.
REQ-004 SHALL drive iss_ready=1 only in IDLE; iss_valid in any other state SHALL be ignored.
REQ-005 SHALL, in IDLE with iss_valid=1:
  - latch opA, opB, isDiv and tag;
  - go to DONE if isDiv=1 and opB=0, with wb_exception=1 and wb_data=0;
  - otherwise go to START.
REQ-006 SHALL, in START with md_inputRDY=1:
  - assert exactly one of md_MULT/md_DIV for exactly one cycle;
  - clear the cycle counter;
  - go to BUSY.
  With md_inputRDY=0 it SHALL stay in START with both pulses low.
REQ-007 SHALL hold md_operandA and md_operandB at the latched values from START until leaving BUSY.
REQ-008 SHALL, in BUSY with md_resultRDY=1, capture md_result and md_exception into wb_data and wb_exception, then go to DONE.
REQ-009 SHALL, in BUSY, increment the counter each cycle without md_resultRDY. On reaching TIMEOUT-1 it SHALL go to DONE with wb_exception=1, wb_timeout=1, wb_data=0.
REQ-010 SHALL give md_resultRDY priority over timeout when both occur in the same cycle.
REQ-011 SHALL assert wb_valid, with wb_tag/wb_data stable, for every cycle in DONE; it SHALL return to IDLE on the cycle wb_ack=1.
REQ-012 SHALL, on flush=1:
  - in START: return to IDLE;
  - in BUSY: enter DRAIN;
  - in DONE: drop wb_valid and return to IDLE;
  - in IDLE: no effect.
REQ-013 SHALL, in DRAIN, wait for md_resultRDY or timeout, discard the result, never assert wb_valid, then return to IDLE.
REQ-014 SHALL assert hazard_stall combinationally when state is START, BUSY or DONE, the latched tag is nonzero, and (rd_tagA or rd_tagB) equals the latched tag.
REQ-015 SHALL treat tag 0 normally for writeback, but tag 0 SHALL never cause hazard_stall.
REQ-016 SHALL ignore md_resultRDY in IDLE, START and DONE.

Reset
REQ-017 SHALL, while ctrl_reset=1 at a rising edge (including mid-operation):
  - go to IDLE;
  - set counter, latched operands, tag, wb_data to 0;
  - set wb_valid, wb_exception, wb_timeout, md_MULT, md_DIV, hazard_stall to 0;
  - set iss_ready=1 from the first cycle after reset.

Structure
REQ-018 SHALL take the FSM state encoding and the default TIMEOUT/TAG_W constants from shared package multdiv_pkg.
REQ-019 SHALL instantiate one sub-module, mdc_timeout_cnt: a clearable, saturating cycle counter with a terminal-count output.

Verification
REQ-020 SHALL be covered by these directed bench scenarios:
  - Mult 1234 × -56, tag 7, model returns resultRDY 5 cycles after md_MULT: single md_MULT pulse, then wb_valid=1, wb_tag=7, wb_data=-69104, wb_exception=0; IDLE one cycle after wb_ack.
  - Div 100000 / 0, tag 3: no md_DIV pulse; wb_valid=1 two cycles after accept with wb_exception=1, wb_data=0.
  - Div -7 / 2 with md_resultRDY held 0, TIMEOUT=48: wb_valid after 48 BUSY cycles with wb_exception=1, wb_timeout=1.
  - Mult in BUSY, flush at cycle 2, resultRDY at cycle 5: no wb_valid; iss_ready=1 one cycle after resultRDY.
  - Pending tag 9 in BUSY with rd_tagB=9: hazard_stall=1; pending tag 0 with rd_tagA=0: hazard_stall=0.
  - ctrl_reset asserted in BUSY: next cycle all outputs 0, iss_ready=1; a late md_resultRDY produces no wb_valid.
